// File: rtl/twiddle_seq.sv
// twiddle_seq: streams the twiddle factors W^k of one radix-2 DIT stage of a
// 1024-point FFT. Values come from an external quarter-wave cosine ROM that
// is read twice per twiddle (C(r), then S(r) = ROM[256-r]). The pair is then
// folded into the right quadrant and saturated to signed Q1.15.
module twiddle_seq #(
    parameter int unsigned LOG2N = 10,
    parameter int unsigned TW_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              stage,
    output logic                    busy,
    output logic                    cfg_err,
    output logic                    twact,
    output logic [LOG2N-3:0]        twa,
    input  logic [TW_W-1:0]         twdr_cos,
    output logic                    tw_valid,
    input  logic                    tw_ready,
    output logic signed [TW_W-1:0]  tw_re,
    output logic signed [TW_W-1:0]  tw_im,
    output logic [LOG2N-1:0]        tw_idx,
    output logic                    tw_last
);

    localparam int unsigned NW        = LOG2N;      // twiddle index width
    localparam int unsigned AW        = LOG2N - 2;  // ROM address width
    localparam int unsigned CW        = LOG2N - 1;  // burst counter width
    localparam int unsigned SW        = 4;          // stage field width
    localparam int unsigned XW        = TW_W + 1;   // headroom for negation
    localparam int unsigned MAX_STAGE = LOG2N - 1;

    localparam logic signed [XW-1:0] POS_MAX = XW'((1 << (TW_W - 1)) - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_B = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;

    logic [2:0]             state_q;
    logic [2:0]             state_d;
    logic [SW-1:0]          stage_q;
    logic [CW-1:0]          n_q;
    logic [TW_W-1:0]        c_q;

    logic [NW-1:0]          idx_c;
    logic [AW-1:0]          r_c;
    logic [AW-1:0]          nxt_r_c;
    logic [1:0]             q_c;
    logic                   last_c;
    logic                   stage_ok_c;
    logic signed [XW-1:0]   c_x;
    logic signed [XW-1:0]   s_x;
    logic signed [XW-1:0]   cos_x;
    logic signed [XW-1:0]   sin_x;
    logic signed [XW-1:0]   im_x;

    // k = n << (9 - s): spreads the stage's 2^s twiddles evenly over 0..511
    function automatic logic [NW-1:0] idx_of(input logic [CW-1:0] n,
                                             input logic [SW-1:0] s);
        return NW'(n) << (SW'(MAX_STAGE) - s);
    endfunction

    // Only +32768 can overflow; the most negative input is exactly -32768
    function automatic logic signed [TW_W-1:0] sat(input logic signed [XW-1:0] v);
        if (v > POS_MAX) begin
            return TW_W'(POS_MAX);
        end
        return TW_W'(v);
    endfunction

    // Index decode, quadrant folding and negation of the two ROM samples
    always_comb begin
        idx_c      = idx_of(n_q, stage_q);
        nxt_r_c    = AW'(idx_of(n_q + CW'(1), stage_q));
        r_c        = idx_c[AW-1:0];
        q_c        = idx_c[NW-1:AW];
        last_c     = (NW'(n_q) == ((NW'(1) << stage_q) - NW'(1)));
        stage_ok_c = (stage <= SW'(MAX_STAGE));
        c_x        = $signed({1'b0, c_q});
        s_x        = '0;
        if (r_c != '0) begin
            s_x = $signed({1'b0, twdr_cos});
        end
        case (q_c)
            2'd0: begin
                cos_x = c_x;
                sin_x = s_x;
            end
            2'd1: begin
                cos_x = -s_x;
                sin_x = c_x;
            end
            2'd2: begin
                cos_x = -c_x;
                sin_x = -s_x;
            end
            default: begin
                cos_x = s_x;
                sin_x = -c_x;
            end
        endcase
        im_x = -sin_x;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && stage_ok_c) begin
                    state_d = RD_A;
                end
            end
            RD_A: state_d = RD_B;
            RD_B: state_d = CAP;
            CAP:  state_d = OUT;
            OUT: begin
                if (tw_ready) begin
                    state_d = tw_last ? IDLE : RD_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, ROM addressing and burst bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            cfg_err  <= 1'b0;
            twact    <= 1'b0;
            twa      <= '0;
            tw_valid <= 1'b0;
            tw_re    <= '0;
            tw_im    <= '0;
            tw_idx   <= '0;
            tw_last  <= 1'b0;
            stage_q  <= '0;
            n_q      <= '0;
            c_q      <= '0;
        end else begin
            cfg_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (stage_ok_c) begin
                            busy    <= 1'b1;
                            stage_q <= stage;
                            n_q     <= '0;
                            twact   <= 1'b1;
                            twa     <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    // (256 - r) mod 256; r = 0 reads address 0, masked later
                    twa <= AW'(0) - r_c;
                end
                RD_B: begin
                    c_q   <= twdr_cos;
                    twact <= 1'b0;
                end
                CAP: begin
                    tw_re    <= sat(cos_x);
                    tw_im    <= sat(im_x);
                    tw_idx   <= idx_c;
                    tw_last  <= last_c;
                    tw_valid <= 1'b1;
                end
                OUT: begin
                    if (tw_ready) begin
                        tw_valid <= 1'b0;
                        if (tw_last) begin
                            tw_last <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            n_q   <= n_q + CW'(1);
                            twact <= 1'b1;
                            twa   <= nxt_r_c;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_twiddle_seq.sv
// tb_twiddle_seq: directed bench for twiddle_seq with a registered cosine ROM
// model and an expected-twiddle queue drained by an independent monitor.
module tb_twiddle_seq;

    localparam real PI = 3.14159265358979323846;

    typedef struct packed {
        logic [9:0]         idx;
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [3:0]         stage;
    logic               busy;
    logic               cfg_err;
    logic               twact;
    logic [7:0]         twa;
    logic [15:0]        twdr_cos;
    logic               tw_valid;
    logic               tw_ready;
    logic signed [15:0] tw_re;
    logic signed [15:0] tw_im;
    logic [9:0]         tw_idx;
    logic               tw_last;

    logic [15:0]        rom [256];
    exp_t               exp_q [$];
    exp_t               mon_exp;
    exp_t               mon_got;
    int                 checks = 0;
    int                 errors = 0;

    twiddle_seq #(.LOG2N(10), .TW_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stage    (stage),
        .busy     (busy),
        .cfg_err  (cfg_err),
        .twact    (twact),
        .twa      (twa),
        .twdr_cos (twdr_cos),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .tw_idx   (tw_idx),
        .tw_last  (tw_last)
    );

    always #5 clk = ~clk;

    // Quarter-wave cosine ROM, one-cycle registered read
    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'($rtoi($floor($cos(2.0 * PI * real'(i) / 1024.0) * 32768.0 + 0.5)));
        end
        twdr_cos = '0;
    end

    always @(posedge clk) begin
        if (twact) twdr_cos <= rom[twa];
    end

    // Monitor: every accepted twiddle is compared against the queue head
    always @(negedge clk) begin
        if (!rst && tw_valid && tw_ready) begin
            checks++;
            mon_got = {tw_idx, tw_re, tw_im, tw_last};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tw_item: unexpected twiddle k=%0d re=%0d im=%0d last=%0d",
                         tw_idx, tw_re, tw_im, tw_last);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL tw_item: got k=%0d re=%0d im=%0d last=%0d, required k=%0d re=%0d im=%0d last=%0d",
                             mon_got.idx, mon_got.re, mon_got.im, mon_got.last,
                             mon_exp.idx, mon_exp.re, mon_exp.im, mon_exp.last);
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int k, input int re, input int im, input bit last);
        exp_t e;
        e.idx  = 10'(k);
        e.re   = 16'(re);
        e.im   = 16'(im);
        e.last = last;
        return e;
    endfunction

    // Reference twiddle straight from the trigonometric definition
    function automatic exp_t model(input int k, input bit last);
        real th;
        int  c;
        int  s;
        th = 2.0 * PI * real'(k) / 1024.0;
        c  = $rtoi($floor($cos(th) * 32768.0 + 0.5));
        s  = $rtoi($floor(-$sin(th) * 32768.0 + 0.5));
        if (c > 32767) c = 32767;
        if (s > 32767) s = 32767;
        return mk(k, c, s, last);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] s);
        start = 1'b1;
        stage = s;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!tw_valid && edges < 50) begin
            tick();
            edges++;
        end
    endtask

    task automatic wait_next(output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (tw_valid && edges < 50);
        while (!tw_valid && edges < 50) begin
            tick();
            edges++;
        end
    endtask

    task automatic wait_idle(input string name, input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        check(name, busy, 0);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic push_stage2();
        exp_q.push_back(mk(0,   32767,  0,      0));
        exp_q.push_back(mk(128, 23170,  -23170, 0));
        exp_q.push_back(mk(256, 0,      -32768, 0));
        exp_q.push_back(mk(384, -23170, -23170, 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int e;
        int n;
        logic [41:0] hold_exp;

        rst      = 1'b1;
        start    = 1'b0;
        stage    = '0;
        tw_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ctrl", {cfg_err, twact, tw_valid, tw_last}, 0);
        check("rst_twa", twa, 0);
        check("rst_data", {tw_re, tw_im, tw_idx}, 0);
        rst = 1'b0;
        tick();

        // Stage 0: a single twiddle
        tw_ready = 1'b1;
        exp_q.push_back(mk(0, 32767, 0, 1));
        do_start(4'd0);
        check("s0_busy", busy, 1);
        wait_valid(e);
        check("s0_latency", e, 3);
        tick();
        check("s0_busy_drop", busy, 0);
        check("s0_valid_drop", tw_valid, 0);
        check("s0_drained", exp_q.size(), 0);

        // Stage 2 at full rate: 4 cycles per twiddle
        push_stage2();
        do_start(4'd2);
        wait_valid(e);
        check("s2_latency", e, 3);
        repeat (3) begin
            wait_next(e);
            check("s2_period", e, 4);
        end
        wait_idle("s2_done", 20);

        // Backpressure on k=128
        push_stage2();
        do_start(4'd2);
        wait_valid(e);
        tick();
        tw_ready = 1'b0;
        wait_valid(e);
        hold_exp = {10'd128, 16'd23170, 16'(-23170)};
        repeat (5) begin
            check("bp_hold", {tw_idx, tw_re, tw_im}, hold_exp);
            check("bp_twact", {twact, tw_valid}, 2'b01);
            tick();
        end
        tw_ready = 1'b1;
        wait_idle("bp_done", 40);

        // Illegal stage while idle
        do_start(4'd12);
        check("ill_cfg_err", cfg_err, 1);
        check("ill_busy", {busy, twact}, 0);
        tick();
        check("ill_cfg_err_pulse", cfg_err, 0);
        repeat (3) tick();
        check("ill_no_reads", {busy, twact, tw_valid}, 0);

        // Starts while busy and on the final handshake are ignored
        push_stage2();
        do_start(4'd2);
        tick();
        do_start(4'd12);
        check("ovl_cfg_err", cfg_err, 0);
        check("ovl_busy", busy, 1);
        do_start(4'd0);
        n = 0;
        while (!(tw_valid && tw_last) && n < 100) begin
            tick();
            n++;
        end
        check("ovl_last_seen", tw_valid && tw_last, 1);
        do_start(4'd0);
        check("ovl_busy_drop", busy, 0);
        repeat (4) begin
            tick();
            check("ovl_no_restart", {busy, twact, tw_valid}, 0);
        end
        check("ovl_drained", exp_q.size(), 0);

        // Stage 9: 512 twiddles, hand values at the notable points
        for (int i = 0; i < 512; i++) begin
            if (i == 1)        exp_q.push_back(mk(1,   32767,  -201,   0));
            else if (i == 255) exp_q.push_back(mk(255, 201,    -32767, 0));
            else if (i == 511) exp_q.push_back(mk(511, -32767, -201,   1));
            else               exp_q.push_back(model(i, 1'b0));
        end
        do_start(4'd9);
        wait_idle("s9_done", 2200);

        // Reset in the middle of a stage-9 burst
        for (int i = 0; i < 38; i++) exp_q.push_back(model(i, 1'b0));
        do_start(4'd9);
        n = 0;
        while (!(tw_valid && tw_idx == 10'd37) && n < 300) begin
            tick();
            n++;
        end
        check("rb_reach_37", tw_valid && tw_idx == 10'd37, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rb_ctrl", {busy, cfg_err, twact, tw_valid, tw_last}, 0);
        check("rb_twa", twa, 0);
        check("rb_data", {tw_re, tw_im, tw_idx}, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back(mk(0,   32767, 0,      0));
        exp_q.push_back(mk(256, 0,     -32768, 1));
        do_start(4'd1);
        wait_idle("rb_s1_done", 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/twiddle_seq.md
Name: twiddle_seq

Overview:
- Sequences the quarter-wave cosine twiddle ROM (`twact`/`twa`/`twdr_cos`, 256 x 16-bit unsigned, 1-cycle registered read, C(0)=32768) for one radix-2 DIT stage of the 1024-point FFT.
- On a start pulse it streams the stage's 2^s twiddles W^k = cos(2πk/N) − j·sin(2πk/N) as signed Q1.15 pairs over a valid/ready handshake.
- The quarter-wave reconstruction is done with two time-multiplexed ROM reads per twiddle.
- Sits between the FFT stage controller and the butterfly unit.

Parameters:
- LOG2N, 10, FFT size exponent; only 10 is supported (ROM depth fixed at N/4 = 256).
- TW_W, 16, twiddle component width (signed Q1.15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a burst
- stage  in  4  stage s, legal 0..9; sampled on accepted start
- busy  out  1  high from accepted start until the final twiddle is accepted
- cfg_err  out  1  one-cycle pulse when start arrives with stage>9 while idle
- twact  out  1  ROM read enable
- twa  out  8  ROM address
- twdr_cos  in  16  ROM data, valid the cycle after twact
- tw_valid  out  1  output twiddle valid
- tw_ready  in  1  consumer ready
- tw_re  out  16  cos(2πk/1024), signed
- tw_im  out  16  −sin(2πk/1024), signed
- tw_idx  out  10  k of the current twiddle
- tw_last  out  1  high with the final twiddle of the burst

Behaviour:
- Reset: `rst` asynchronous, active-high. Every output goes to 0 immediately, the FSM returns to IDLE, and `twact` is 0. Reset asserted mid-burst abandons the burst.
- Burst: an accepted stage s yields n = 0..2^s−1 with k = n << (9−s), giving k in 0..511.
- Quadrant split: q = k[9:8], r = k[7:0].
  - C(r) = ROM[r].
  - S(r) = 0 when r = 0, else ROM[256−r].
- Reconstruction:
  - q0: cos = C, sin = S.
  - q1: cos = −S, sin = C.
  - q2: cos = −C, sin = −S.
  - q3: cos = S, sin = −C.
  - tw_im = −sin.
- Saturation: magnitude 32768 maps to +32767 when the result is positive and to −32768 exactly when negated. Zero stays 0.
- FSM states:
  - IDLE: `busy` = 0. On `start` with stage ≤ 9: latch s, n = 0, go to RD_A. On `start` with stage > 9: pulse `cfg_err`, stay in IDLE.
  - RD_A: `twact` = 1, `twa` = r. Go to RD_B.
  - RD_B: `twact` = 1, `twa` = (256−r)[7:0] (0 when r = 0). Go to CAP. The ROM returns C during this state.
  - CAP: register C from `twdr_cos` at the end of RD_B's following edge. Then register `tw_re`, `tw_im`, `tw_idx` and `tw_last` = (n = 2^s−1). Set `tw_valid` = 1 and go to OUT.
  - OUT: hold every output stable while `tw_ready` = 0, with `twact` = 0.
    - On `tw_valid` & `tw_ready` with not last: n++ and go to RD_A, with `tw_valid` deasserting.
    - On `tw_valid` & `tw_ready` with last: clear `tw_valid`/`tw_last`, `busy` = 0, go to IDLE.
- Latency: `tw_valid` rises 3 clk edges after the start-accepting edge. Steady-state throughput is one twiddle per 4 cycles with `tw_ready` held high.
- `twact` is 0 in IDLE, CAP and OUT. `twa` holds its last value when `twact` = 0.
- `start` while busy: ignored, no `cfg_err`.
- `start` in the same cycle the final handshake occurs: ignored. A new `start` is accepted only in IDLE.
- Arithmetic: negation and saturation are done in 17 bits, then clipped to 16.

Test Plan:
- Stage 0: start, stage=0 -> exactly one twiddle: k=0, tw_re=32767, tw_im=0, tw_last=1, tw_valid 3 edges after start; busy drops after the handshake.
- Stage 2, tw_ready=1 -> k=0,128,256,384 with (re,im) = (32767,0), (23170,−23170), (0,−32768), (−23170,−23170); tw_last only on k=384; 4 cycles per item.
- Stage 9 -> 512 items with k=n.
  - k=1 gives (32767,−201).
  - k=255 gives (201,−32767).
  - k=511 gives (−32767,−201).
  - tw_last only at n=511.
- Backpressure: stage 2, tw_ready=0 for 5 cycles on k=128 -> tw_re/tw_im/tw_idx stable, twact=0 throughout; stream resumes with k=256.
- Illegal and overlapping starts: stage=12 while idle -> cfg_err for one cycle, busy stays 0, no ROM reads; start during a stage-2 burst -> ignored, the burst completes normally.
- Reset mid-burst: rst during stage 9 at n=37 -> all outputs 0 before the next edge, twact=0; a new start with stage=1 afterwards yields k=0 then k=256.
